// File: rtl/mem_issue.sv
// mem_issue: dual-lane memory request issue stage.
// Registers the upper/lower lane requests toward the memory stage. When both
// lanes hit the same word and at least one of them writes, the pair is issued
// over two cycles (upper first), and the execute stage is held meanwhile.
// Out-of-range addresses are truncated, their stores are suppressed, and a
// sticky error flag is raised.
module mem_issue #(
    parameter int ADDR_BITS = 17,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 interlock,
    input  logic                 u_valid,
    input  logic                 l_valid,
    input  logic [31:0]          u_addr,
    input  logic [31:0]          l_addr,
    input  logic [31:0]          u_din,
    input  logic [31:0]          l_din,
    input  logic                 u_we,
    input  logic                 l_we,
    input  logic                 err_clr,
    output logic                 stall_out,
    output logic                 u_out_valid,
    output logic                 l_out_valid,
    output logic [ADDR_BITS-1:0] u_out_addr,
    output logic [ADDR_BITS-1:0] l_out_addr,
    output logic [31:0]          u_out_din,
    output logic [31:0]          l_out_din,
    output logic                 u_out_we,
    output logic                 l_out_we,
    output logic                 addr_err,
    output logic [CNT_W-1:0]     conflict_cnt
);

    localparam logic [0:0] PASS  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] h_addr_q, h_addr_d;
    logic [31:0]          h_din_q, h_din_d;
    logic                 h_we_q, h_we_d;
    logic                 u_ov_q, u_ov_d, l_ov_q, l_ov_d;
    logic [ADDR_BITS-1:0] u_oa_q, u_oa_d, l_oa_q, l_oa_d;
    logic [31:0]          u_od_q, u_od_d, l_od_q, l_od_d;
    logic                 u_ow_q, u_ow_d, l_ow_q, l_ow_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic u_oor, l_oor, conflict, err_set;

    // Lane checks: upper address bits must be zero; same-word pair with a store is a hazard.
    assign u_oor    = u_valid & ((u_addr >> ADDR_BITS) != 32'd0);
    assign l_oor    = l_valid & ((l_addr >> ADDR_BITS) != 32'd0);
    assign conflict = u_valid & l_valid & (u_we | l_we) &
                      (u_addr[ADDR_BITS-1:0] == l_addr[ADDR_BITS-1:0]);

    // Next-state: issue both, issue upper and park lower, or drain the parked lane.
    always_comb begin
        state_d  = state_q;
        h_addr_d = h_addr_q;
        h_din_d  = h_din_q;
        h_we_d   = h_we_q;
        u_ov_d   = u_ov_q;
        u_oa_d   = u_oa_q;
        u_od_d   = u_od_q;
        u_ow_d   = u_ow_q;
        l_ov_d   = l_ov_q;
        l_oa_d   = l_oa_q;
        l_od_d   = l_od_q;
        l_ow_d   = l_ow_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        err_set  = 1'b0;
        if (!interlock) begin
            if (state_q == SPLIT) begin
                // Held lower lane goes out alone; its store enable was already screened.
                u_ov_d  = 1'b0;
                u_ow_d  = 1'b0;
                l_ov_d  = 1'b1;
                l_oa_d  = h_addr_q;
                l_od_d  = h_din_q;
                l_ow_d  = h_we_q;
                state_d = PASS;
            end else begin
                err_set = u_oor | l_oor;
                u_ov_d  = u_valid;
                u_ow_d  = u_valid & u_we & ~u_oor;
                if (u_valid) begin
                    u_oa_d = u_addr[ADDR_BITS-1:0];
                    u_od_d = u_din;
                end
                if (conflict) begin
                    l_ov_d   = 1'b0;
                    l_ow_d   = 1'b0;
                    h_addr_d = l_addr[ADDR_BITS-1:0];
                    h_din_d  = l_din;
                    h_we_d   = l_we & ~l_oor;
                    state_d  = SPLIT;
                    if (!(&cnt_q))
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    l_ov_d = l_valid;
                    l_ow_d = l_valid & l_we & ~l_oor;
                    if (l_valid) begin
                        l_oa_d = l_addr[ADDR_BITS-1:0];
                        l_od_d = l_din;
                    end
                end
            end
            // A new error outranks a clear in the same cycle.
            err_d = err_set | (err_q & ~err_clr);
        end
    end

    // State and output registers; reset drops any parked lower lane.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= PASS;
            h_addr_q <= '0;
            h_din_q  <= '0;
            h_we_q   <= 1'b0;
            u_ov_q   <= 1'b0;
            u_oa_q   <= '0;
            u_od_q   <= '0;
            u_ow_q   <= 1'b0;
            l_ov_q   <= 1'b0;
            l_oa_q   <= '0;
            l_od_q   <= '0;
            l_ow_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            h_addr_q <= h_addr_d;
            h_din_q  <= h_din_d;
            h_we_q   <= h_we_d;
            u_ov_q   <= u_ov_d;
            u_oa_q   <= u_oa_d;
            u_od_q   <= u_od_d;
            u_ow_q   <= u_ow_d;
            l_ov_q   <= l_ov_d;
            l_oa_q   <= l_oa_d;
            l_od_q   <= l_od_d;
            l_ow_q   <= l_ow_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stall_out    = interlock | (state_q == SPLIT);
    assign u_out_valid  = u_ov_q;
    assign u_out_addr   = u_oa_q;
    assign u_out_din    = u_od_q;
    assign u_out_we     = u_ow_q;
    assign l_out_valid  = l_ov_q;
    assign l_out_addr   = l_oa_q;
    assign l_out_din    = l_od_q;
    assign l_out_we     = l_ow_q;
    assign addr_err     = err_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_issue.sv
// Directed bench for mem_issue: vector table plus hand-written multi-cycle sequences.
module tb_mem_issue;

    localparam int AB = 17;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          interlock, u_valid, l_valid, u_we, l_we, err_clr;
    logic [31:0]   u_addr, l_addr, u_din, l_din;
    logic          stall_out, u_out_valid, l_out_valid, u_out_we, l_out_we, addr_err;
    logic [AB-1:0] u_out_addr, l_out_addr;
    logic [31:0]   u_out_din, l_out_din;
    logic [CW-1:0] conflict_cnt;

    int n_chk = 0;
    int n_fail = 0;

    mem_issue #(.ADDR_BITS(AB), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .interlock(interlock),
        .u_valid(u_valid), .l_valid(l_valid), .u_addr(u_addr), .l_addr(l_addr),
        .u_din(u_din), .l_din(l_din), .u_we(u_we), .l_we(l_we), .err_clr(err_clr),
        .stall_out(stall_out), .u_out_valid(u_out_valid), .l_out_valid(l_out_valid),
        .u_out_addr(u_out_addr), .l_out_addr(l_out_addr),
        .u_out_din(u_out_din), .l_out_din(l_out_din),
        .u_out_we(u_out_we), .l_out_we(l_out_we),
        .addr_err(addr_err), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        il, uv; logic [31:0] ua, ud; logic uw;
        logic        lv; logic [31:0] la, ld; logic lw; logic clr;
        logic        e_uov; logic [31:0] e_uoa, e_uod; logic e_uow;
        logic        e_lov; logic [31:0] e_loa, e_lod; logic e_low;
        logic        e_err; logic [31:0] e_cnt; logic e_stall;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic il, input logic uv, input logic [31:0] ua, input logic [31:0] ud,
                         input logic uw, input logic lv, input logic [31:0] la, input logic [31:0] ld,
                         input logic lw, input logic clr);
        interlock = il; u_valid = uv; u_addr = ua; u_din = ud; u_we = uw;
        l_valid = lv; l_addr = la; l_din = ld; l_we = lw; err_clr = clr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        idle();
        rstn = 1'b0;
        #1;
        chk("rst u_out_valid", {31'd0, u_out_valid}, 0);
        chk("rst l_out_valid", {31'd0, l_out_valid}, 0);
        chk("rst stall_out", {31'd0, stall_out}, 0);
        chk("rst conflict_cnt", {28'd0, conflict_cnt}, 0);
        chk("rst addr_err", {31'd0, addr_err}, 0);
        @(negedge clk);
        rstn = 1'b1;

        //             il uv ua           ud            uw lv la           ld     lw clr | uov uoa       uod           uow lov loa   lod    low err cnt st
        vecs[0]  = '{0, 1, 32'h10,      32'h1,        0, 1, 32'h20,      32'h2, 1, 0,   1, 32'h10,   32'h1,        0, 1, 32'h20, 32'h2, 1, 0, 0, 0};
        vecs[1]  = '{0, 1, 32'h40,      32'hAAAA5555, 1, 1, 32'h40,      32'h3, 0, 0,   1, 32'h40,   32'hAAAA5555, 1, 0, 32'h20, 32'h2, 0, 0, 1, 1};
        vecs[2]  = '{0, 1, 32'h99,      32'h9,        1, 1, 32'h99,      32'h9, 1, 0,   0, 32'h40,   32'hAAAA5555, 0, 1, 32'h40, 32'h3, 0, 0, 1, 0};
        vecs[3]  = '{0, 1, 32'h40,      32'h5,        0, 1, 32'h40,      32'h6, 0, 0,   1, 32'h40,   32'h5,        0, 1, 32'h40, 32'h6, 0, 0, 1, 0};
        vecs[4]  = '{0, 1, 32'h20004,   32'h7,        1, 0, 32'h123,     32'h0, 1, 0,   1, 32'h4,    32'h7,        0, 0, 32'h40, 32'h6, 0, 1, 1, 0};
        vecs[5]  = '{0, 0, 32'h0,       32'h0,        0, 0, 32'h0,       32'h0, 0, 1,   0, 32'h4,    32'h7,        0, 0, 32'h40, 32'h6, 0, 0, 1, 0};
        vecs[6]  = '{0, 1, 32'h20008,   32'h8,        1, 0, 32'h0,       32'h0, 0, 1,   1, 32'h8,    32'h8,        0, 0, 32'h40, 32'h6, 0, 1, 1, 0};
        vecs[7]  = '{1, 1, 32'h30,      32'h9,        1, 1, 32'h31,      32'h9, 1, 1,   1, 32'h8,    32'h8,        0, 0, 32'h40, 32'h6, 0, 1, 1, 1};
        vecs[8]  = '{0, 0, 32'h0,       32'h0,        0, 0, 32'h0,       32'h0, 0, 1,   0, 32'h8,    32'h8,        0, 0, 32'h40, 32'h6, 0, 0, 1, 0};
        vecs[9]  = '{0, 1, 32'h50,      32'hA,        1, 1, 32'h20050,   32'hB, 1, 0,   1, 32'h50,   32'hA,        1, 0, 32'h40, 32'h6, 0, 1, 2, 1};
        vecs[10] = '{0, 0, 32'h0,       32'h0,        0, 0, 32'h0,       32'h0, 0, 0,   0, 32'h50,   32'hA,        0, 1, 32'h50, 32'hB, 0, 1, 2, 0};
        vecs[11] = '{0, 0, 32'h0,       32'h0,        0, 0, 32'h0,       32'h0, 0, 1,   0, 32'h50,   32'hA,        0, 0, 32'h50, 32'hB, 0, 0, 2, 0};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].il, vecs[i].uv, vecs[i].ua, vecs[i].ud, vecs[i].uw,
                  vecs[i].lv, vecs[i].la, vecs[i].ld, vecs[i].lw, vecs[i].clr);
            step();
            chk($sformatf("v%0d u_out_valid", i), {31'd0, u_out_valid}, {31'd0, vecs[i].e_uov});
            chk($sformatf("v%0d u_out_addr", i),  {15'd0, u_out_addr},  vecs[i].e_uoa);
            chk($sformatf("v%0d u_out_din", i),   u_out_din,            vecs[i].e_uod);
            chk($sformatf("v%0d u_out_we", i),    {31'd0, u_out_we},    {31'd0, vecs[i].e_uow});
            chk($sformatf("v%0d l_out_valid", i), {31'd0, l_out_valid}, {31'd0, vecs[i].e_lov});
            chk($sformatf("v%0d l_out_addr", i),  {15'd0, l_out_addr},  vecs[i].e_loa);
            chk($sformatf("v%0d l_out_din", i),   l_out_din,            vecs[i].e_lod);
            chk($sformatf("v%0d l_out_we", i),    {31'd0, l_out_we},    {31'd0, vecs[i].e_low});
            chk($sformatf("v%0d addr_err", i),    {31'd0, addr_err},    {31'd0, vecs[i].e_err});
            chk($sformatf("v%0d conflict_cnt", i), {28'd0, conflict_cnt}, vecs[i].e_cnt);
            chk($sformatf("v%0d stall_out", i),   {31'd0, stall_out},   {31'd0, vecs[i].e_stall});
        end

        // Interlock held for three cycles while in SPLIT
        drive(0, 1, 32'h60, 32'hC, 1, 1, 32'h60, 32'hD, 0, 0);
        step();
        chk("il entry u_out_valid", {31'd0, u_out_valid}, 1);
        chk("il entry cnt", {28'd0, conflict_cnt}, 3);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 32'h77, 32'hE, 1, 1, 32'h78, 32'hF, 1, 0);
            step();
            chk($sformatf("il%0d u_out_valid", k), {31'd0, u_out_valid}, 1);
            chk($sformatf("il%0d u_out_addr", k), {15'd0, u_out_addr}, 32'h60);
            chk($sformatf("il%0d l_out_valid", k), {31'd0, l_out_valid}, 0);
            chk($sformatf("il%0d stall_out", k), {31'd0, stall_out}, 1);
            chk($sformatf("il%0d cnt", k), {28'd0, conflict_cnt}, 3);
        end
        idle();
        #1;
        chk("il release stall_out", {31'd0, stall_out}, 1);
        step();
        chk("il drain u_out_valid", {31'd0, u_out_valid}, 0);
        chk("il drain l_out_valid", {31'd0, l_out_valid}, 1);
        chk("il drain l_out_addr", {15'd0, l_out_addr}, 32'h60);
        chk("il drain l_out_din", l_out_din, 32'hD);
        chk("il drain stall_out", {31'd0, stall_out}, 0);
        step();
        chk("il once l_out_valid", {31'd0, l_out_valid}, 0);

        // Saturate the counter: 12 more conflicts take it from 3 to 15
        for (int k = 0; k < 12; k++) begin
            drive(0, 1, 32'h100 + k, 32'h0, 0, 1, 32'h100 + k, 32'h0, 1, 0);
            step();
            idle();
            step();
        end
        chk("sat cnt at max", {28'd0, conflict_cnt}, 32'hF);
        drive(0, 1, 32'h200, 32'h0, 1, 1, 32'h200, 32'h0, 1, 0);
        step();
        chk("sat cnt holds", {28'd0, conflict_cnt}, 32'hF);
        chk("sat stall_out", {31'd0, stall_out}, 1);

        // Reset mid-SPLIT: everything clears at once, parked lane is dropped
        idle();
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst u_out_valid", {31'd0, u_out_valid}, 0);
        chk("midrst u_out_addr", {15'd0, u_out_addr}, 0);
        chk("midrst l_out_valid", {31'd0, l_out_valid}, 0);
        chk("midrst stall_out", {31'd0, stall_out}, 0);
        chk("midrst cnt", {28'd0, conflict_cnt}, 0);
        chk("midrst addr_err", {31'd0, addr_err}, 0);
        @(negedge clk);
        rstn = 1'b1;
        drive(0, 1, 32'h70, 32'h12, 0, 0, 32'h0, 32'h0, 0, 0);
        step();
        chk("post rst u_out_valid", {31'd0, u_out_valid}, 1);
        chk("post rst u_out_addr", {15'd0, u_out_addr}, 32'h70);
        chk("post rst l_out_valid", {31'd0, l_out_valid}, 0);
        chk("post rst stall_out", {31'd0, stall_out}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_issue.md
MEM_ISSUE -- requirements
Module: mem_issue

Interface
REQ-001 Parameter ADDR_BITS, default 17, word-address width presented to the memory stage.
REQ-002 Parameter CNT_W, default 16, conflict counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 interlock  input  1  downstream stall; when 1, block holds all state and outputs.
REQ-006 u_valid / l_valid  input  1 each  upper/lower lane memory request present.
REQ-007 u_addr / l_addr  input  32 each  word address from execute.
REQ-008 u_din / l_din  input  32 each  store data.
REQ-009 u_we / l_we  input  1 each  store enable.
REQ-010 err_clr  input  1  clears addr_err.
REQ-011 stall_out  output  1  hold request to execute stage.
REQ-012 u_out_valid / l_out_valid  output  1 each  registered lane request valid to memory stage.
REQ-013 u_out_addr / l_out_addr  output  ADDR_BITS each  registered word address.
REQ-014 u_out_din / l_out_din  output  32 each  registered store data.
REQ-015 u_out_we / l_out_we  output  1 each  registered store enable.
REQ-016 addr_err  output  1  sticky out-of-range flag.
REQ-017 conflict_cnt  output  CNT_W  saturating count of serialized pairs.

Function
REQ-018 Conflict SHALL be: u_valid & l_valid & (u_addr[ADDR_BITS-1:0] == l_addr[ADDR_BITS-1:0]) & (u_we | l_we); two reads of one address are not a conflict.
REQ-019 FSM SHALL have two states, PASS and SPLIT; reset state PASS.
REQ-020 PASS, no conflict, interlock=0: both lanes SHALL be registered to outputs next posedge; remain PASS.
REQ-021 PASS, conflict, interlock=0: upper lane SHALL be issued (l_out_valid=0), lower lane (addr, din, we) captured into hold register, go SPLIT.
REQ-022 SPLIT, interlock=0: held lower lane SHALL be issued on l_out_* with u_out_valid=0; inputs ignored; return to PASS.
REQ-023 Upper lane SHALL always reach memory before or with the lower lane (program order).
REQ-024 stall_out SHALL equal interlock | (state==SPLIT), combinational.
REQ-025 interlock=1: state, hold register, outputs, counter, addr_err set/clear SHALL all hold; inputs ignored.
REQ-026 Out-of-range: valid lane with addr[31:ADDR_BITS] != 0 SHALL set addr_err next posedge; request still issued with truncated address and out_we forced 0.
REQ-027 Out-of-range check applies at capture time; held lane carries its already-forced we.
REQ-028 err_clr=1 SHALL clear addr_err; simultaneous set and clear: set wins.
REQ-029 conflict_cnt SHALL increment by 1 on each PASS->SPLIT transition; saturates at all-ones.
REQ-030 Invalid lane: out_valid=0 and out_we=0; out_addr/out_din SHALL hold previous value.
REQ-031 Latency: one cycle input-to-output without conflict; conflicting pair completes in two cycles.

Reset
REQ-032 rstn=0 SHALL immediately force state PASS, hold register cleared, all outputs 0, addr_err=0, conflict_cnt=0.
REQ-033 Reset asserted in SPLIT SHALL discard the held lower lane; no issue after release.
REQ-034 First request after rstn release SHALL be sampled on the first posedge with rstn=1.

Verification
REQ-035 u read 0x10, l write 0x20 -> next cycle both out_valid=1, addrs 0x10/0x20, l_out_we=1, stall_out=0, conflict_cnt=0.
REQ-036 u write 0x40 din 0xAAAA5555, l read 0x40 -> cycle1 u issued only, stall_out=1; cycle2 l issued only, addr 0x40; conflict_cnt=1.
REQ-037 both read 0x40 -> issued together, no SPLIT, conflict_cnt=0.
REQ-038 u write addr 0x0002_0004 -> u_out_addr=0x00004, u_out_we=0, addr_err=1; err_clr pulse -> addr_err=0; err_clr coincident with new error -> addr_err stays 1.
REQ-039 conflict entered, interlock=1 for 3 cycles in SPLIT -> outputs frozen, stall_out=1; release -> held lane issued once.
REQ-040 preload conflict_cnt to all-ones via 2^CNT_W-1 conflicts (CNT_W=4 build) -> further conflict leaves 0xF; rstn pulse mid-SPLIT -> all outputs 0, state PASS.
